hazard_forward_tracker: RTL and testbench

- Sequential hazard/forwarding control for the 5-stage pipeline.
- Tracks destination-register state of instructions in flight through ID/EX, EX/MEM and MEM/WB.
- Drives the 2-bit forward_select codes consumed by the two EX-stage operand forwarding muxes.
- Raises a load-use stall toward PC/IF-ID and inserts a bubble into its own ID/EX entry.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/fwd_select_logic.sv | 43 ++++
 rtl/hazard_forward_tracker.sv | 106 ++++++++++
 tb/tb_hazard_forward_tracker.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard/forwarding control.
//   - Forward-select encodings. They must match the EX operand mux.
//   - The architectural zero-register index.
//   - Packed entry types for the ID/EX, EX/MEM and MEM/WB tracked stages.
package pipe_pkg;

  localparam int PIPE_AW = 5;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEMWB = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  localparam logic [PIPE_AW-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic               valid;
    logic [PIPE_AW-1:0] rs1;
    logic [PIPE_AW-1:0] rs2;
    logic               use1;
    logic               use2;
    logic [PIPE_AW-1:0] rd;
    logic               regwrite;
    logic               memread;
  } idex_entry_t;

  typedef struct packed {
    logic [PIPE_AW-1:0] rd;
    logic               regwrite;
    logic               memread;
  } exmem_entry_t;

  typedef struct packed {
    logic [PIPE_AW-1:0] rd;
    logic               regwrite;
  } memwb_entry_t;

endpackage

// File: rtl/fwd_select_logic.sv
// Forward-select priority for one EX-stage operand.
// This block is purely combinational. It compares the operand's source register
// against the EX/MEM and MEM/WB producers. The younger producer (EX/MEM) wins.
// Register 0 is never forwarded.
// Ports:
//   ex_valid       ID/EX holds a real instruction
//   ex_use         instruction actually reads this operand
//   ex_rs          source register index of this operand
//   exmem_regwrite EX/MEM producer writes its rd
//   exmem_rd       EX/MEM destination register
//   memwb_regwrite MEM/WB producer writes its rd
//   memwb_rd       MEM/WB destination register
//   fwd_sel        mux select (FWD_RF / FWD_MEMWB / FWD_EXMEM)
module fwd_select_logic
  import pipe_pkg::*;
#(
  parameter int REG_AW = PIPE_AW
) (
  input  logic              ex_valid,
  input  logic              ex_use,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic              exmem_regwrite,
  input  logic [REG_AW-1:0] exmem_rd,
  input  logic              memwb_regwrite,
  input  logic [REG_AW-1:0] memwb_rd,
  output logic [1:0]        fwd_sel
);

  logic reads;
  logic hit_exmem;
  logic hit_memwb;

  assign reads     = ex_valid & ex_use;
  assign hit_exmem = reads & exmem_regwrite & (exmem_rd != '0) & (exmem_rd == ex_rs);
  assign hit_memwb = reads & memwb_regwrite & (memwb_rd != '0) & (memwb_rd == ex_rs);

  always_comb begin
    fwd_sel = FWD_RF;
    if (hit_exmem)      fwd_sel = FWD_EXMEM;
    else if (hit_memwb) fwd_sel = FWD_MEMWB;
  end

endmodule

// File: rtl/hazard_forward_tracker.sv
// Hazard and forwarding control for the 5-stage pipeline.
// It tracks the destination-register state of instructions in ID/EX, EX/MEM and
// MEM/WB. From that state it drives the EX operand forward selects.
// It also detects load-use hazards. On a hazard it stalls PC/IF-ID and puts a
// bubble into ID/EX. Stages downstream of ID/EX always advance.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   id_*                    decode-stage instruction fields
//   flush_i                 squash the instruction entering ID/EX
//   forward_a_o/forward_b_o EX operand A/B mux selects
//   stall_o                 load-use stall (combinational)
//   stall_cnt_o             saturating count of stall cycles since reset
// The stage entry types are fixed at pipe_pkg::PIPE_AW bits. REG_AW must match it.
module hazard_forward_tracker
  import pipe_pkg::*;
#(
  parameter int REG_AW = PIPE_AW,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              id_valid_i,
  input  logic [REG_AW-1:0] id_rs1_i,
  input  logic [REG_AW-1:0] id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [REG_AW-1:0] id_rd_i,
  input  logic              id_regwrite_i,
  input  logic              id_memread_i,
  input  logic              flush_i,
  output logic [1:0]        forward_a_o,
  output logic [1:0]        forward_b_o,
  output logic              stall_o,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  idex_entry_t  idex_q;
  exmem_entry_t exmem_q;
  memwb_entry_t memwb_q;
  logic [CNT_W-1:0] stall_cnt_q;

  // A load sits in ID/EX and the decode instruction reads its rd.
  // flush_i does not mask the stall. Both cases insert the same bubble.
  always_comb begin
    stall_o = idex_q.valid & idex_q.memread & (idex_q.rd != REG_ZERO) & id_valid_i &
              ((id_use_rs1_i & (id_rs1_i == idex_q.rd)) |
               (id_use_rs2_i & (id_rs2_i == idex_q.rd)));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
    end else begin
      memwb_q.rd       <= exmem_q.rd;
      memwb_q.regwrite <= exmem_q.regwrite;
      exmem_q.rd       <= idex_q.rd;
      // A bubble already carries regwrite=0 and memread=0.
      // Copying the ID/EX fields straight through is therefore enough.
      exmem_q.regwrite <= idex_q.regwrite;
      exmem_q.memread  <= idex_q.memread;
      if (stall_o || flush_i || !id_valid_i) begin
        idex_q <= '0;
      end else begin
        idex_q.valid    <= 1'b1;
        idex_q.rs1      <= id_rs1_i;
        idex_q.rs2      <= id_rs2_i;
        idex_q.use1     <= id_use_rs1_i;
        idex_q.use2     <= id_use_rs2_i;
        idex_q.rd       <= id_rd_i;
        idex_q.regwrite <= id_regwrite_i;
        idex_q.memread  <= id_memread_i;
      end
      if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
        stall_cnt_q <= stall_cnt_q + 1'b1;
      end
    end
  end

  assign stall_cnt_o = stall_cnt_q;

  fwd_select_logic #(.REG_AW(REG_AW)) u_fwd_a (
    .ex_valid       (idex_q.valid),
    .ex_use         (idex_q.use1),
    .ex_rs          (idex_q.rs1),
    .exmem_regwrite (exmem_q.regwrite),
    .exmem_rd       (exmem_q.rd),
    .memwb_regwrite (memwb_q.regwrite),
    .memwb_rd       (memwb_q.rd),
    .fwd_sel        (forward_a_o)
  );

  fwd_select_logic #(.REG_AW(REG_AW)) u_fwd_b (
    .ex_valid       (idex_q.valid),
    .ex_use         (idex_q.use2),
    .ex_rs          (idex_q.rs2),
    .exmem_regwrite (exmem_q.regwrite),
    .exmem_rd       (exmem_q.rd),
    .memwb_regwrite (memwb_q.regwrite),
    .memwb_rd       (memwb_q.rd),
    .fwd_sel        (forward_b_o)
  );

endmodule

// File: tb/tb_hazard_forward_tracker.sv
module tb_hazard_forward_tracker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic       id_use1 = 1'b0;
  logic       id_use2 = 1'b0;
  logic [4:0] id_rd = '0;
  logic       id_rw = 1'b0;
  logic       id_mr = 1'b0;
  logic       flush = 1'b0;

  logic [1:0]  fa, fb, fa_s, fb_s;
  logic        stall, stall_s;
  logic [15:0] cnt;
  logic [1:0]  cnt_s;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  hazard_forward_tracker #(.REG_AW(5), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2), .id_rd_i(id_rd),
    .id_regwrite_i(id_rw), .id_memread_i(id_mr), .flush_i(flush),
    .forward_a_o(fa), .forward_b_o(fb), .stall_o(stall), .stall_cnt_o(cnt)
  );

  hazard_forward_tracker #(.REG_AW(5), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .id_valid_i(id_valid), .id_rs1_i(id_rs1), .id_rs2_i(id_rs2),
    .id_use_rs1_i(id_use1), .id_use_rs2_i(id_use2), .id_rd_i(id_rd),
    .id_regwrite_i(id_rw), .id_memread_i(id_mr), .flush_i(flush),
    .forward_a_o(fa_s), .forward_b_o(fb_s), .stall_o(stall_s), .stall_cnt_o(cnt_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // valid, rs1, rs2, use1, use2, rd, regwrite, memread; then settle
  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic rw, input logic mr);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_use1 = u1; id_use2 = u2;
    id_rd = rd; id_rw = rw; id_mr = mr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    // reset
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    chk("rst_fa", fa, 0);
    chk("rst_fb", fb, 0);
    chk("rst_stall", stall, 0);
    chk("rst_cnt", cnt, 0);
    rst = 1'b0;

    // back-to-back ALU dependency
    drive(1, 1, 2, 1, 1, 5, 1, 0); tick();
    drive(1, 5, 6, 1, 1, 10, 1, 0);
    chk("b2b_nostall", stall, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_fa", fa, 2'b10);
    chk("b2b_fb", fb, 2'b00);
    nops(3);

    // distance-2 dependency
    drive(1, 0, 0, 0, 0, 7, 1, 0); tick();
    drive(1, 1, 2, 1, 1, 8, 1, 0); tick();
    drive(1, 1, 7, 1, 1, 12, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("d2_fb", fb, 2'b01);
    chk("d2_fa", fa, 2'b00);
    nops(3);

    // double match: EX/MEM wins
    drive(1, 0, 0, 0, 0, 3, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 3, 1, 0); tick();
    drive(1, 3, 3, 1, 1, 13, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("dbl_fa", fa, 2'b10);
    chk("dbl_fb", fb, 2'b10);
    nops(3);

    // load-use
    drive(1, 0, 0, 0, 0, 9, 1, 1); tick();
    drive(1, 9, 0, 1, 0, 11, 1, 0);
    chk("lu_stall", stall, 1);
    chk("lu_cnt0", cnt, 0);
    tick();
    chk("lu_stall_1cyc", stall, 0);
    chk("lu_cnt1", cnt, 1);
    chk("lu_bubble_fa", fa, 2'b00);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_after_fa", fa, 2'b01);
    chk("lu_after_stall", stall, 0);
    nops(3);

    // x0 producer
    drive(1, 0, 0, 0, 0, 0, 1, 0); tick();
    drive(1, 0, 0, 1, 0, 14, 1, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("x0_fa", fa, 2'b00);
    nops(3);

    // x0 load never stalls
    drive(1, 0, 0, 0, 0, 0, 1, 1); tick();
    drive(1, 0, 0, 1, 0, 14, 1, 0);
    chk("x0_load_stall", stall, 0);
    nops(3);

    // flushed load
    flush = 1'b1;
    drive(1, 0, 0, 0, 0, 4, 1, 1); tick();
    flush = 1'b0;
    drive(1, 4, 0, 1, 0, 15, 1, 0);
    chk("flush_stall", stall, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("flush_fa", fa, 2'b00);
    chk("flush_cnt", cnt, 1);
    nops(3);

    // reset during a stall
    drive(1, 0, 0, 0, 0, 9, 1, 1); tick();
    drive(1, 9, 0, 1, 0, 11, 1, 0);
    chk("rs_stall_pre", stall, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("rs_fa", fa, 0);
    chk("rs_fb", fb, 0);
    chk("rs_stall", stall, 0);
    chk("rs_cnt", cnt, 0);
    chk("rs_cnt_sat", cnt_s, 0);

    // saturation: five load-use stalls
    for (int i = 0; i < 5; i++) begin
      drive(1, 0, 0, 0, 0, 9, 1, 1); tick();
      drive(1, 0, 9, 0, 1, 11, 1, 0);
      chk("sat_stall", stall_s, 1);
      tick();
      if (i == 2) chk("sat_cnt_at3", cnt_s, 3);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    chk("sat_cnt_hold", cnt_s, 3);
    chk("wide_cnt5", cnt, 5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
